// File: rtl/mips_pkg.sv
// Shared MIPS core types for the store path.
// Size codes, the formatted store entry and word geometry.
package mips_pkg;

  localparam int WORD_BYTES = 4;
  localparam int ADDR_W     = 32;
  localparam int DATA_W     = 8 * WORD_BYTES;

  typedef enum logic [1:0] {
    SZ_BYTE = 2'b00,
    SZ_HALF = 2'b01,
    SZ_WORD = 2'b10,
    SZ_ILL  = 2'b11
  } mem_size_e;

  typedef struct packed {
    logic [ADDR_W-1:0]     addr;
    logic [DATA_W-1:0]     wdata;
    logic [WORD_BYTES-1:0] be;
  } store_entry_t;

endpackage

// File: rtl/store_fmt.sv
// Store formatter: narrows and lane-replicates a store operand.
// Purely combinational; flags misaligned or illegal requests.
module store_fmt
  import mips_pkg::*;
(
  input  logic [ADDR_W-1:0] addr,
  input  logic [DATA_W-1:0] data,
  input  mem_size_e         size,
  output store_entry_t      entry,
  output logic              misaligned
);

  // Map size and lane to replicated data, byte enables and error flag
  always_comb begin
    entry      = '0;
    misaligned = 1'b0;
    entry.addr = {addr[ADDR_W-1:2], 2'b00};
    unique case (size)
      SZ_BYTE: begin
        entry.wdata = {4{data[7:0]}};
        entry.be    = 4'b0001 << addr[1:0];
      end
      SZ_HALF: begin
        entry.wdata = {2{data[15:0]}};
        entry.be    = addr[1] ? 4'b1100 : 4'b0011;
        misaligned  = addr[0];
      end
      SZ_WORD: begin
        entry.wdata = data;
        entry.be    = 4'b1111;
        misaligned  = (addr[1:0] != 2'b00);
      end
      SZ_ILL: begin
        misaligned = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/store_narrow_buffer.sv
// Store narrowing buffer: formats stores and queues them in a FIFO.
// Drains the head entry to data memory over valid/ready.
module store_narrow_buffer
  import mips_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int AW    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     st_valid,
  output logic                     st_ready,
  input  logic [AW-1:0]            st_addr,
  input  logic [31:0]              st_data,
  input  logic [1:0]               st_size,
  output logic                     st_err,
  output logic                     mem_valid,
  input  logic                     mem_ready,
  output logic [AW-1:0]            mem_addr,
  output logic [31:0]              mem_wdata,
  output logic [3:0]               mem_be,
  output logic [$clog2(DEPTH)+1-1:0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  store_entry_t fmt_entry;
  logic         fmt_bad;
  store_entry_t fifo_q [DEPTH];
  store_entry_t head;
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          accept;
  logic          push;
  logic          pop;

  store_fmt u_fmt (
    .addr       (ADDR_W'(st_addr)),
    .data       (st_data),
    .size       (mem_size_e'(st_size)),
    .entry      (fmt_entry),
    .misaligned (fmt_bad)
  );

  assign st_ready  = (count != CW'(DEPTH));
  assign mem_valid = (count != '0);
  assign accept    = st_valid && st_ready;
  assign push      = accept && !fmt_bad;
  assign pop       = mem_valid && mem_ready;
  assign head      = fifo_q[rd_ptr];

  // Gate head fields so outputs read zero while the buffer is empty
  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    mem_be    = '0;
    if (mem_valid) begin
      mem_addr  = AW'(head.addr);
      mem_wdata = head.wdata;
      mem_be    = head.be;
    end
  end

  // Entry storage; contents are don't-care until pushed
  always_ff @(posedge clk) begin
    if (push) begin
      fifo_q[wr_ptr] <= fmt_entry;
    end
  end

  // Pointers, occupancy and the one-cycle error pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      st_err <= 1'b0;
    end else begin
      st_err <= accept && fmt_bad;
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule
